alu_pipe: RTL

Pipelined, parametrised successor to the combinational `alu`. It registers operands and results with valid/ready handshakes on both sides and adds left shift, set-less-than (signed and unsigned) and an illegal-opcode error flag. It also keeps sticky overflow/carry status. It sits between the operand/decode stage and writeback, and sustains one operation per cycle with a fixed 2-cycle latency under no backpressure.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_core.sv | 55 +++++
 rtl/alu_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode encodings and the per-result flag bundle shared by the ALU pipeline
// and the decode stage.
package alu_pkg;

   localparam logic [5:0] OP_ADD  = 6'b100000;
   localparam logic [5:0] OP_SUB  = 6'b100010;
   localparam logic [5:0] OP_AND  = 6'b100100;
   localparam logic [5:0] OP_OR   = 6'b100101;
   localparam logic [5:0] OP_XOR  = 6'b100110;
   localparam logic [5:0] OP_NOR  = 6'b100111;
   localparam logic [5:0] OP_SRL  = 6'b000010;
   localparam logic [5:0] OP_SRA  = 6'b000011;
   localparam logic [5:0] OP_SLL  = 6'b000000;
   localparam logic [5:0] OP_SLT  = 6'b101010;
   localparam logic [5:0] OP_SLTU = 6'b101011;

   typedef struct packed {
      logic zero;
      logic overflow;
      logic carry;
      logic error;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: computes result and flags from the captured
// operands and opcode. Undefined opcodes yield result 0 with only error/zero set.
module alu_core
   import alu_pkg::*;
#(
   parameter int N       = 8,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic [5:0]   op_i,
   output logic [N-1:0] res_o,
   output alu_flags_t   flags_o
);

   logic [N:0]         sum_s;
   logic [N:0]         diff_s;
   logic [SHAMT_W-1:0] shamt_s;

   // Result and flag selection; the subtract borrow is the top bit of the
   // zero-extended difference, which equals unsigned A<B.
   always_comb begin
      sum_s            = {1'b0, a_i} + {1'b0, b_i};
      diff_s           = {1'b0, a_i} - {1'b0, b_i};
      shamt_s          = b_i[SHAMT_W-1:0];
      res_o            = '0;
      flags_o.overflow = 1'b0;
      flags_o.carry    = 1'b0;
      flags_o.error    = 1'b0;
      case (op_i)
         OP_ADD: begin
            res_o            = sum_s[N-1:0];
            flags_o.overflow = (a_i[N-1] == b_i[N-1]) && (sum_s[N-1] != a_i[N-1]);
            flags_o.carry    = sum_s[N];
         end
         OP_SUB: begin
            res_o            = diff_s[N-1:0];
            flags_o.overflow = (a_i[N-1] != b_i[N-1]) && (diff_s[N-1] != a_i[N-1]);
            flags_o.carry    = diff_s[N];
         end
         OP_AND:  res_o = a_i & b_i;
         OP_OR:   res_o = a_i | b_i;
         OP_XOR:  res_o = a_i ^ b_i;
         OP_NOR:  res_o = ~(a_i | b_i);
         OP_SRL:  res_o = a_i >> shamt_s;
         OP_SRA:  res_o = $signed(a_i) >>> shamt_s;
         OP_SLL:  res_o = a_i << shamt_s;
         OP_SLT:  res_o = {{(N-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         OP_SLTU: res_o = {{(N-1){1'b0}}, (a_i < b_i)};
         default: flags_o.error = 1'b1;
      endcase
      flags_o.zero = (res_o == '0);
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides: S1 captures operands,
// S2 holds the computed result and drives the outputs; sticky V/C accumulate.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int N       = 8,
   parameter int SHAMT_W = $clog2(N)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_datoA,
   input  logic [N-1:0] i_datoB,
   input  logic [5:0]   i_operacion,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_resultado,
   output logic         o_zero,
   output logic         o_overflow,
   output logic         o_carry,
   output logic         o_error,
   input  logic         i_clr_sticky,
   output logic         o_sticky_v,
   output logic         o_sticky_c
);

   logic         s1_valid_q, s1_valid_d;
   logic [N-1:0] s1_a_q, s1_a_d;
   logic [N-1:0] s1_b_q, s1_b_d;
   logic [5:0]   s1_op_q, s1_op_d;
   logic         s2_valid_q, s2_valid_d;
   logic [N-1:0] s2_res_q, s2_res_d;
   alu_flags_t   s2_flags_q, s2_flags_d;
   logic         sticky_v_q, sticky_v_d;
   logic         sticky_c_q, sticky_c_d;

   logic         adv2_s;
   logic         in_hs_s;
   logic         out_hs_s;
   logic [N-1:0] core_res_s;
   alu_flags_t   core_flags_s;

   alu_core #(
      .N       (N),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .a_i     (s1_a_q),
      .b_i     (s1_b_q),
      .op_i    (s1_op_q),
      .res_o   (core_res_s),
      .flags_o (core_flags_s)
   );

   assign adv2_s   = !s2_valid_q || i_ready;
   assign o_ready  = !s1_valid_q || adv2_s;
   assign in_hs_s  = i_valid && o_ready;
   assign out_hs_s = s2_valid_q && i_ready;

   // Stage advance, stall and sticky next-state; data registers keep their
   // last value when no new item arrives.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_flags_d = s2_flags_q;
      sticky_v_d = sticky_v_q;
      sticky_c_d = sticky_c_q;

      if (adv2_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d   = core_res_s;
            s2_flags_d = core_flags_s;
         end else begin
            s2_res_d   = s2_res_q;
            s2_flags_d = s2_flags_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end

      if (in_hs_s) begin
         s1_valid_d = 1'b1;
         s1_a_d     = i_datoA;
         s1_b_d     = i_datoB;
         s1_op_d    = i_operacion;
      end else if (adv2_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end

      if (i_clr_sticky) begin
         sticky_v_d = 1'b0;
         sticky_c_d = 1'b0;
      end else if (out_hs_s) begin
         sticky_v_d = sticky_v_q | s2_flags_q.overflow;
         sticky_c_d = sticky_c_q | s2_flags_q.carry;
      end else begin
         sticky_v_d = sticky_v_q;
         sticky_c_d = sticky_c_q;
      end
   end

   // Pipeline and sticky state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= 6'b000000;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_flags_q <= '0;
         sticky_v_q <= 1'b0;
         sticky_c_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_flags_q <= s2_flags_d;
         sticky_v_q <= sticky_v_d;
         sticky_c_q <= sticky_c_d;
      end
   end

   assign o_valid     = s2_valid_q;
   assign o_resultado = s2_res_q;
   assign o_zero      = s2_flags_q.zero;
   assign o_overflow  = s2_flags_q.overflow;
   assign o_carry     = s2_flags_q.carry;
   assign o_error     = s2_flags_q.error;
   assign o_sticky_v  = sticky_v_q;
   assign o_sticky_c  = sticky_c_q;

endmodule
